// File: rtl/bdf_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// bdf_sched_ctrl_if
//
// Bundles every bdf_sched_ctrl signal except clk and rst.
//   master : the side that programs and controls the scheduler
//            (drives load/start/stop, observes toggles and status)
//   slave  : the scheduler itself
//
// Signals
//   load_ctrl       write ctrl_in into the next schedule slot
//   ctrl_in         schedule word; [NUM_BUFFS-1:0] write toggles,
//                   [CTRL_WIDTH-1:NUM_BUFFS] read toggles
//   period_in       iteration period, sampled on start (0 or >depth = depth)
//   iter_num_in     iterations to run, sampled on start (0 = forever)
//   start_ctrl      start replay
//   stop_ctrl       stop request
//   stop_mode       0 = immediate stop, 1 = stop at iteration boundary
//   buff_wr_toggle  per-buffer write bank toggle pulses
//   buff_rd_toggle  per-buffer read bank toggle pulses
//   busy            high while replaying
//   iter_done       pulse on the last slot of each iteration
//   iter_count      completed iterations since start, saturating
//   load_err        sticky load overflow / load-while-running flag
//   sched_err       sticky toggle-balance violation flag
// ---------------------------------------------------------------------------
interface bdf_sched_ctrl_if #(
  parameter int NUM_BUFFS  = 12,
  parameter int CTRL_DEPTH = 48,
  parameter int CNT_WIDTH  = 16,
  parameter int CTRL_WIDTH = 2 * NUM_BUFFS,
  parameter int PW         = $clog2(CTRL_DEPTH + 1)
);
  logic                  load_ctrl;
  logic [CTRL_WIDTH-1:0] ctrl_in;
  logic [PW-1:0]         period_in;
  logic [CNT_WIDTH-1:0]  iter_num_in;
  logic                  start_ctrl;
  logic                  stop_ctrl;
  logic                  stop_mode;
  logic [NUM_BUFFS-1:0]  buff_wr_toggle;
  logic [NUM_BUFFS-1:0]  buff_rd_toggle;
  logic                  busy;
  logic                  iter_done;
  logic [CNT_WIDTH-1:0]  iter_count;
  logic                  load_err;
  logic                  sched_err;

  modport master (
    output load_ctrl, ctrl_in, period_in, iter_num_in,
           start_ctrl, stop_ctrl, stop_mode,
    input  buff_wr_toggle, buff_rd_toggle, busy, iter_done,
           iter_count, load_err, sched_err
  );

  modport slave (
    input  load_ctrl, ctrl_in, period_in, iter_num_in,
           start_ctrl, stop_ctrl, stop_mode,
    output buff_wr_toggle, buff_rd_toggle, busy, iter_done,
           iter_count, load_err, sched_err
  );
endinterface

// File: rtl/bdf_sched_ctrl.sv
// ---------------------------------------------------------------------------
// bdf_sched_ctrl
//
// Schedule controller for the BDF dataflow pipeline. A static table of
// buffer-toggle words is loaded while idle, then replayed cyclically with a
// runtime period, optional iteration limit and immediate or boundary stop.
//
// Ports
//   clk   single clock
//   rst   synchronous, active-high reset (table contents are kept)
//   bus   bdf_sched_ctrl_if.slave: load/start/stop controls, per-buffer
//         write/read toggle pulses, busy/iter_done/iter_count/load_err/
//         sched_err status
//
// Optional feature
//   BDF_SCHED_TOGGLE_CHK_EN : when defined, per-buffer signed wr-minus-rd
//   toggle counters are checked at each iteration end and any imbalance
//   sets sched_err. When undefined, sched_err is tied to 0.
// ---------------------------------------------------------------------------
module bdf_sched_ctrl #(
  parameter int NUM_BUFFS  = 12,
  parameter int CTRL_DEPTH = 48,
  parameter int CNT_WIDTH  = 16,
  parameter int CTRL_WIDTH = 2 * NUM_BUFFS,
  parameter int PW         = $clog2(CTRL_DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  bdf_sched_ctrl_if.slave bus
);

  localparam int AW = (CTRL_DEPTH > 1) ? $clog2(CTRL_DEPTH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [PW-1:0] DEPTH_P = PW'(CTRL_DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  // Schedule table (no reset, so it survives rst and can map to block RAM)
  logic [CTRL_WIDTH-1:0] table_mem [CTRL_DEPTH];
  logic [CTRL_WIDTH-1:0] rd_word_q;
  logic                  mem_we;
  logic [PW-1:0]         rd_addr;

  logic [0:0]           state_q,      state_d;
  logic [PW-1:0]        slot_q,       slot_d;
  logic [PW-1:0]        period_q,     period_d;
  logic [CNT_WIDTH-1:0] target_q,     target_d;
  logic [CNT_WIDTH-1:0] iter_count_q, iter_count_d;
  logic                 iter_done_q,  iter_done_d;
  logic [PW-1:0]        load_ptr_q,   load_ptr_d;
  logic                 load_err_q,   load_err_d;
  logic                 stop_pend_q,  stop_pend_d;

  logic                 busy;
  logic                 start_acc;
  logic                 last_slot;
  logic                 stop_now;
  logic                 end_iter;
  logic [PW-1:0]        period_eff;
  logic [PW-1:0]        next_slot;
  logic [CNT_WIDTH-1:0] count_inc;
  logic [NUM_BUFFS-1:0] wr_vis;
  logic [NUM_BUFFS-1:0] rd_vis;

  assign busy      = (state_q == ST_RUN);
  assign start_acc = !busy && bus.start_ctrl;
  assign last_slot = (slot_q == period_q - ONE_P);

  // Out-of-range periods fall back to the full table
  assign period_eff = ((bus.period_in == '0) || (bus.period_in > DEPTH_P))
                      ? DEPTH_P : bus.period_in;

  assign count_inc = (iter_count_q == '1) ? iter_count_q
                                          : iter_count_q + CNT_WIDTH'(1);

  // -------------------------------------------------------------------------
  // Next-state logic. slot_q is the slot whose toggles are on the outputs
  // this cycle; rd_addr selects the slot to be shown in the next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    period_d     = period_q;
    target_d     = target_q;
    iter_count_d = iter_count_q;
    iter_done_d  = 1'b0;
    load_ptr_d   = load_ptr_q;
    load_err_d   = load_err_q;
    stop_pend_d  = stop_pend_q;
    mem_we       = 1'b0;
    rd_addr      = '0;
    stop_now     = 1'b0;
    end_iter     = 1'b0;
    next_slot    = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_ctrl) begin
          if (load_ptr_q == DEPTH_P) begin
            load_err_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            load_ptr_d = load_ptr_q + ONE_P;
          end
        end
        // Start wins over a coincident stop; stop is simply not looked at here
        if (bus.start_ctrl) begin
          state_d      = ST_RUN;
          slot_d       = '0;
          rd_addr      = '0;
          period_d     = period_eff;
          target_d     = bus.iter_num_in;
          load_ptr_d   = '0;
          load_err_d   = 1'b0;
          stop_pend_d  = 1'b0;
          // A one-slot period completes an iteration on its very first slot
          iter_done_d  = (period_eff == ONE_P);
          iter_count_d = (period_eff == ONE_P) ? CNT_WIDTH'(1) : '0;
        end
      end

      default: begin // ST_RUN
        if (bus.load_ctrl) begin
          load_err_d = 1'b1;
        end
        if (bus.stop_ctrl && bus.stop_mode) begin
          stop_pend_d = 1'b1;
        end
        stop_now = bus.stop_ctrl && !bus.stop_mode;
        // The boundary request is honoured even if it arrives on the last slot
        end_iter = last_slot &&
                   (stop_pend_q || (bus.stop_ctrl && bus.stop_mode) ||
                    ((target_q != '0) && (iter_count_q == target_q)));

        if (stop_now || end_iter) begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
        end else begin
          next_slot   = last_slot ? '0 : slot_q + ONE_P;
          slot_d      = next_slot;
          rd_addr     = next_slot;
          // iter_done and the count update line up with the last slot's toggles
          iter_done_d = (next_slot == period_q - ONE_P);
          if (next_slot == period_q - ONE_P) begin
            iter_count_d = count_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      period_q     <= '0;
      target_q     <= '0;
      iter_count_q <= '0;
      iter_done_q  <= 1'b0;
      load_ptr_q   <= '0;
      load_err_q   <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      period_q     <= period_d;
      target_q     <= target_d;
      iter_count_q <= iter_count_d;
      iter_done_q  <= iter_done_d;
      load_ptr_q   <= load_ptr_d;
      load_err_q   <= load_err_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  // Table write port and registered read port
  always_ff @(posedge clk) begin
    if (mem_we) begin
      table_mem[load_ptr_q[AW-1:0]] <= bus.ctrl_in;
    end
    rd_word_q <= table_mem[rd_addr[AW-1:0]];
  end

  // The read register itself has no reset; busy_q masks it so toggles are
  // zero in IDLE, after an immediate stop and right after rst.
  assign wr_vis = busy ? rd_word_q[NUM_BUFFS-1:0]          : '0;
  assign rd_vis = busy ? rd_word_q[CTRL_WIDTH-1:NUM_BUFFS] : '0;

  assign bus.buff_wr_toggle = wr_vis;
  assign bus.buff_rd_toggle = rd_vis;
  assign bus.busy           = busy;
  assign bus.iter_done      = iter_done_q;
  assign bus.iter_count     = iter_count_q;
  assign bus.load_err       = load_err_q;

`ifdef BDF_SCHED_TOGGLE_CHK_EN
  // Counter range is +/-CTRL_DEPTH within one iteration; two spare bits
  // cover the sign and the worst case.
  localparam int BW = PW + 2;

  logic [NUM_BUFFS-1:0] bal_nz;
  logic                 iter_end_chk;
  logic                 sched_err_q, sched_err_d;

  // Checked on the cycle the last slot is shown, including that slot's toggles
  assign iter_end_chk = busy && last_slot;

  for (genvar gi = 0; gi < NUM_BUFFS; gi++) begin : g_bal
    logic signed [BW-1:0] bal_q, bal_d;
    logic signed [BW-1:0] bal_sum;

    always_comb begin
      bal_sum = bal_q + $signed(BW'(wr_vis[gi])) - $signed(BW'(rd_vis[gi]));
      if (!busy || iter_end_chk) begin
        bal_d = '0;
      end else begin
        bal_d = bal_sum;
      end
    end

    assign bal_nz[gi] = (bal_sum != '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        bal_q <= '0;
      end else begin
        bal_q <= bal_d;
      end
    end
  end

  always_comb begin
    sched_err_d = sched_err_q;
    if (start_acc) begin
      sched_err_d = 1'b0;
    end else if (iter_end_chk && (|bal_nz)) begin
      sched_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sched_err_q <= 1'b0;
    end else begin
      sched_err_q <= sched_err_d;
    end
  end

  assign bus.sched_err = sched_err_q;
`else
  assign bus.sched_err = 1'b0;
`endif

endmodule

// File: tb/tb_bdf_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bdf_sched_ctrl
//
// Randomised bench for bdf_sched_ctrl. Expected outputs of each run are
// derived from the run length: with effective period P, display cycle k
// (k = 0 is the cycle after start) shows slot k%P, iter_done on k%P==P-1 and
// floor((k+1)/P) completed iterations; the run length L follows from the
// target and the stop request.
// ---------------------------------------------------------------------------
module tb_bdf_sched_ctrl;

  localparam int NB    = 6;
  localparam int DEPTH = 10;
  localparam int CW    = 3;
  localparam int CTW   = 2 * NB;
  localparam int PW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bdf_sched_ctrl_if #(.NUM_BUFFS(NB), .CTRL_DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  bdf_sched_ctrl #(.NUM_BUFFS(NB), .CTRL_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference copy of the schedule table and load bookkeeping
  logic [CTW-1:0] tbl_m [DEPTH];
  int             ld_ptr_m;
  bit             ld_err_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.load_ctrl   = 1'b0;
    bus.ctrl_in     = '0;
    bus.period_in   = '0;
    bus.iter_num_in = '0;
    bus.start_ctrl  = 1'b0;
    bus.stop_ctrl   = 1'b0;
    bus.stop_mode   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},   32'(bus.busy), 0);
    chk({tag, ".wr"},     32'(bus.buff_wr_toggle), 0);
    chk({tag, ".rd"},     32'(bus.buff_rd_toggle), 0);
    chk({tag, ".done"},   32'(bus.iter_done), 0);
    chk({tag, ".count"},  32'(bus.iter_count), 0);
    chk({tag, ".lerr"},   32'(bus.load_err), 0);
    chk({tag, ".serr"},   32'(bus.sched_err), 0);
  endtask

  // Load n words; balanced words carry identical wr and rd fields
  task automatic load_words(input int n, input bit balanced);
    logic [NB-1:0]  h;
    logic [CTW-1:0] w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h = NB'($urandom);
      w = balanced ? {h, h} : CTW'($urandom);
      bus.load_ctrl = 1'b1;
      bus.ctrl_in   = w;
      if (ld_ptr_m < DEPTH) begin
        tbl_m[ld_ptr_m] = w;
        ld_ptr_m++;
      end else begin
        ld_err_m = 1'b1;
      end
    end
    @(negedge clk);
    bus.load_ctrl = 1'b0;
    @(negedge clk);
    chk("load_err", 32'(bus.load_err), 32'(ld_err_m));
    $display("[TB] load %0d words balanced=%0d load_err=%0d", n, balanced, bus.load_err);
  endtask

  // One replay: start, optional stop request at display cycle stop_at,
  // optional load attempt during the run at display cycle load_at.
  task automatic run_check(input int per_in, input int iters, input int stop_at,
                           input bit smode, input bit stop_with_start, input int load_at);
    int             p, len, lim, cnt_max, cnt_exp, s;
    bit             imb, busy_e, serr_e;
    logic [CTW-1:0] w;
    string          t;

    p       = (per_in == 0 || per_in > DEPTH) ? DEPTH : per_in;
    cnt_max = (1 << CW) - 1;
    len     = (iters == 0) ? 32'h7fff_ffff : iters * p;
    if (stop_at >= 0) begin
      lim = smode ? (stop_at / p + 1) * p : stop_at + 1;
      if (lim < len) len = lim;
    end
    if (len > 2000) len = 2000; // guard against an unbounded request

    imb = 1'b0;
    for (int b = 0; b < NB; b++) begin
      s = 0;
      for (int j = 0; j < p; j++) begin
        w = tbl_m[j];
        s += int'(w[b]) - int'(w[NB + b]);
      end
      if (s != 0) imb = 1'b1;
    end

    @(negedge clk);
    bus.period_in   = PW'(per_in);
    bus.iter_num_in = CW'(iters);
    bus.start_ctrl  = 1'b1;
    bus.stop_ctrl   = stop_with_start;
    bus.stop_mode   = 1'($urandom);
    ld_ptr_m = 0;
    ld_err_m = 1'b0;

    for (int k = 0; k < len + 3; k++) begin
      @(negedge clk);
      bus.start_ctrl = 1'b0;
      bus.stop_ctrl  = 1'b0;
      bus.load_ctrl  = 1'b0;
      busy_e  = (k < len);
      w       = busy_e ? tbl_m[k % p] : '0;
      cnt_exp = busy_e ? (k + 1) / p : len / p;
      if (cnt_exp > cnt_max) cnt_exp = cnt_max;
`ifdef BDF_SCHED_TOGGLE_CHK_EN
      serr_e = imb && (((k < len) ? k : len) >= p);
`else
      serr_e = 1'b0;
`endif
      t = $sformatf("P%0d.k%0d", p, k);
      chk({t, ".busy"},  32'(bus.busy), 32'(busy_e));
      chk({t, ".wr"},    32'(bus.buff_wr_toggle), 32'(w[NB-1:0]));
      chk({t, ".rd"},    32'(bus.buff_rd_toggle), 32'(w[CTW-1:NB]));
      chk({t, ".done"},  32'(bus.iter_done), 32'(busy_e && (k % p == p - 1)));
      chk({t, ".count"}, 32'(bus.iter_count), 32'(cnt_exp));
      chk({t, ".lerr"},  32'(bus.load_err), 32'(ld_err_m));
      chk({t, ".serr"},  32'(bus.sched_err), 32'(serr_e));
      if (k == stop_at) begin
        bus.stop_ctrl = 1'b1;
        bus.stop_mode = smode;
      end
      if (k == load_at && k < len) begin
        bus.load_ctrl = 1'b1;
        bus.ctrl_in   = CTW'($urandom);
        ld_err_m      = 1'b1;
      end
    end
    $display("[TB] run period_in=%0d iters=%0d stop_at=%0d mode=%0d len=%0d count=%0d",
             per_in, iters, stop_at, smode, len, bus.iter_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, it, sa, n;
    bit sm;

    idle_inputs();
    rst      = 1'b1;
    ld_ptr_m = 0;
    ld_err_m = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Basic: 4 words, 3 iterations of period 4
    load_words(4, 1'b0);
    run_check(4, 3, -1, 1'b0, 1'b0, -1);

    // Overflow: DEPTH+1 words, then a full-depth replay proves table intact
    load_words(DEPTH + 1, 1'b0);
    run_check(0, 2, -1, 1'b0, 1'b0, -1);

    // Run forever, boundary stop at slot 2
    run_check(6, 0, 2, 1'b1, 1'b0, -1);

    // Immediate stop at slot 2 of the second iteration, with a load in RUN
    run_check(5, 0, 7, 1'b0, 1'b0, 1);

    // period_in = 0 with start and stop in the same idle cycle
    run_check(0, 1, -1, 1'b0, 1'b1, -1);

    // Period above the table depth
    run_check(15, 1, -1, 1'b0, 1'b0, -1);

    // Immediate stop coincident with the last slot
    run_check(3, 0, 5, 1'b0, 1'b0, -1);

    // One-slot period: iteration counter saturates
    run_check(1, 0, 11, 1'b0, 1'b0, -1);

    // Randomised runs, with partial reloads in between
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 4);
      if (n > 0) load_words(n, 1'b0);
      per = $urandom_range(0, 15);
      it  = $urandom_range(0, 4);
      sm  = 1'($urandom);
      if (it == 0 || $urandom_range(0, 1) == 1) sa = $urandom_range(0, 25);
      else sa = -1;
      run_check(per, it, sa, sm, 1'($urandom), ($urandom_range(0, 3) == 0) ? 1 : -1);
    end

    // Balanced table keeps sched_err low
    load_words(DEPTH, 1'b1);
    run_check(0, 2, -1, 1'b0, 1'b0, -1);

    // Reset in the middle of a run, then confirm the table survived
    load_words(4, 1'b0);
    @(negedge clk);
    bus.period_in   = PW'(4);
    bus.iter_num_in = '0;
    bus.start_ctrl  = 1'b1;
    @(negedge clk);
    bus.start_ctrl = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun.busy", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrun_rst");
    ld_ptr_m = 0;
    ld_err_m = 1'b0;
    $display("[TB] reset during run");
    run_check(0, 1, -1, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bdf_sched_ctrl.md
# bdf_sched_ctrl

Parametrised single-clock schedule controller for the BDF dataflow pipeline, successor to the fixed 12-buffer / 48-slot controller. It stores a static buffer-toggle schedule, then replays it cyclically, driving per-buffer write/read bank-toggle pulses into the buff_controller instances. Over its predecessor it adds:

- runtime-programmable iteration period;
- finite iteration count;
- graceful or immediate stop;
- status outputs.

## Interface
Parameters:
- NUM_BUFFS, 12, number of buffer controllers driven
- CTRL_DEPTH, 48, schedule table depth (max iteration period in cycles)
- CNT_WIDTH, 16, iteration counter width
- CTRL_WIDTH, 2*NUM_BUFFS, schedule word width (derived; do not override)
- PW, $clog2(CTRL_DEPTH+1), period field width (derived)

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset, synchronous, active-high
- load_ctrl  in  1  write ctrl_in into the next table slot
- ctrl_in  in  CTRL_WIDTH  schedule word; [NUM_BUFFS-1:0] write toggles, [CTRL_WIDTH-1:NUM_BUFFS] read toggles
- period_in  in  PW  iteration period, sampled on start
- iter_num_in  in  CNT_WIDTH  iterations to run, sampled on start; 0 = run forever
- start_ctrl  in  1  start replay
- stop_ctrl  in  1  stop request
- stop_mode  in  1  0 = immediate stop, 1 = stop at iteration boundary; sampled with stop_ctrl
- buff_wr_toggle  out  NUM_BUFFS  per-buffer write bank toggle, one-cycle pulses
- buff_rd_toggle  out  NUM_BUFFS  per-buffer read bank toggle, one-cycle pulses
- busy  out  1  high while in RUN
- iter_done  out  1  one-cycle pulse on the last slot of each iteration
- iter_count  out  CNT_WIDTH  completed iterations since start, saturating
- load_err  out  1  sticky: load overflow or load during RUN
- sched_err  out  1  sticky: toggle-balance violation (see Configuration)

## Operation
- Reset values:
  - state IDLE;
  - all outputs 0;
  - load pointer 0;
  - slot counter 0.
  - Table contents are not reset.
- States:
  - IDLE → RUN on start_ctrl.
  - RUN → IDLE on one of:
    - immediate stop;
    - boundary stop reaching the last slot;
    - iteration target reached.
- Loading (IDLE only):
  - Each cycle with load_ctrl=1 writes table[load_ptr] and increments load_ptr.
  - A write with load_ptr==CTRL_DEPTH is dropped and sets load_err.
  - load_ctrl in RUN is dropped and sets load_err.
  - Accepting start resets load_ptr to 0 and clears load_err.
- Start capture:
  - period_in is captured as the period; a value of 0 or greater than CTRL_DEPTH is treated as CTRL_DEPTH.
  - iter_num_in is captured as the target.
  - iter_count is cleared.
- RUN:
  - Slot counter steps 0 … period-1 and wraps.
  - Outputs are registered: buff_wr_toggle/buff_rd_toggle = table[slot] fields.
  - On slot period-1: pulse iter_done and increment iter_count, saturating at all-ones.
  - If target≠0 and the incremented count equals target, return to IDLE.
- Stop:
  - stop_mode=0: toggles forced to 0 from the next cycle; enter IDLE; the partial iteration is not counted.
  - stop_mode=1: latch a pending stop and finish the current iteration, including iter_done; then enter IDLE.
  - stop_ctrl in IDLE is ignored.
- Simultaneous events:
  - start_ctrl in RUN is ignored.
  - start and stop in the same IDLE cycle: start is accepted, stop is ignored.
  - Immediate stop coincident with the last slot: that slot's toggles and iter_done are emitted, then IDLE.

## Timing
- start_ctrl sampled at edge T:
  - busy=1 and slot-0 toggles are visible from T+1;
  - slot k is visible at T+1+k.
- iter_done is coincident with the slot period-1 toggles.
- busy falls the cycle after the final slot; toggles are 0 in that cycle.
- Immediate stop sampled at edge S: toggles and busy are 0 from S+1.
- A new start is accepted the cycle after busy falls.
- rst mid-RUN: all outputs are 0 the next cycle; the table keeps its contents.

## Configuration
- BDF_SCHED_TOGGLE_CHK_EN defined:
  - Per-buffer signed wr-minus-rd toggle counters are checked at each iteration end.
  - Any nonzero count sets sched_err (sticky until rst or start); counters then clear.
- Undefined: no counters; sched_err is tied to 0.

## Test plan
- Load 4 words, period_in=4, iter_num_in=3, start → 12 cycles of toggles matching table slots 0-3 repeating, iter_done at cycles 4/8/12, iter_count=3, busy low at cycle 13.
- Load CTRL_DEPTH+1 words → load_err=1, table[0..CTRL_DEPTH-1] intact; start clears load_err.
- iter_num_in=0, period 6, stop_mode=1 stop at slot 2 → slots 3-5 emitted, iter_done, then IDLE with iter_count incremented.
- Immediate stop at slot 2 of iteration 1 → toggles 0 next cycle, iter_count=1, no iter_done.
- period_in=0 → replays CTRL_DEPTH slots; start and stop in the same IDLE cycle → run starts.
- With BDF_SCHED_TOGGLE_CHK_EN: buffer 3 has 2 wr toggles and 1 rd toggle per iteration → sched_err=1 after the first iter_done; balanced table → sched_err stays 0.
